// File: rtl/freq_div_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
// Rates assume a 50 MHz sys_clk.
package freq_div_pkg;

    localparam int unsigned CNT_W_DEF  = 25;
    localparam int unsigned SYS_CLK_HZ = 50_000_000;

    localparam logic [CNT_W_DEF-1:0] HALF_1HZ   = 25'd24999999;
    localparam logic [CNT_W_DEF-1:0] HALF_100HZ = 25'd249999;
    localparam logic [CNT_W_DEF-1:0] HALF_1KHZ  = 25'd24999;

    function automatic int unsigned half_for(input int unsigned freq_hz);
        return SYS_CLK_HZ / (2 * freq_hz) - 1;
    endfunction

endpackage

// File: rtl/freq_div_ch.sv
// One divider channel: half-period counter, reprogrammable half_reg,
// enable/idle handling and a boundary output used to time config applies.
module freq_div_ch
    import freq_div_pkg::*;
#(
    parameter int unsigned      CNT_W    = CNT_W_DEF,
    parameter logic [CNT_W-1:0] DEF_HALF = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             align_i,
    input  logic             apply_i,
    input  logic [CNT_W-1:0] half_i,
    output logic             tc_o,
    output logic             clk_o,
    output logic             tick_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] half_q, half_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic             act_q, act_d;
    logic             term;
    logic             stop_now;

    assign term     = act_q && (cnt_q == half_q);
    // Disabling while low stops at once so no runt high pulse appears.
    assign stop_now = act_q && !en_i && !clk_q;
    assign tc_o     = !act_q || term || stop_now || align_i;

    always_comb begin
        cnt_d  = cnt_q;
        half_d = half_q;
        clk_d  = clk_q;
        tick_d = 1'b0;
        act_d  = act_q;
        if (!act_q) begin
            cnt_d = '0;
            clk_d = 1'b0;
            act_d = en_i;
        end else if (align_i) begin
            cnt_d = '0;
            clk_d = 1'b0;
            act_d = en_i;
        end else if (stop_now) begin
            cnt_d = '0;
            clk_d = 1'b0;
            act_d = 1'b0;
        end else if (term) begin
            cnt_d  = '0;
            clk_d  = !clk_q;
            tick_d = !clk_q;
            act_d  = en_i;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        if (apply_i) begin
            half_d = half_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            half_q <= DEF_HALF;
            clk_q  <= 1'b0;
            tick_q <= 1'b0;
            act_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            half_q <= half_d;
            clk_q  <= clk_d;
            tick_q <= tick_d;
            act_q  <= act_d;
        end
    end

    assign clk_o  = clk_q;
    assign tick_o = tick_q;

endmodule

// File: rtl/freq_div_multi.sv
// N-channel programmable clock divider with a single-slot config port.
// Optional FREQ_DIV_SYNC_ALIGN_EN adds sync_align for phase alignment.
module freq_div_multi
    import freq_div_pkg::*;
#(
    parameter int unsigned      NUM_CH = 3,
    parameter int unsigned      CNT_W  = CNT_W_DEF,
    parameter int unsigned      CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    parameter logic [CNT_W-1:0] DEFAULT_HALF [NUM_CH] =
        '{HALF_1HZ, HALF_100HZ, HALF_1KHZ}
) (
    input  logic              sys_clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] ch_en,
`ifdef FREQ_DIV_SYNC_ALIGN_EN
    input  logic              sync_align,
`endif
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_half,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick
);

    logic              pend_q, pend_d;
    logic [CH_W-1:0]   pch_q, pch_d;
    logic [CNT_W-1:0]  phalf_q, phalf_d;
    logic [NUM_CH-1:0] tc;
    logic [NUM_CH-1:0] apply;
    logic              ch_ok;
    logic              capture;
    logic              align;

`ifdef FREQ_DIV_SYNC_ALIGN_EN
    assign align = sync_align;
`else
    assign align = 1'b0;
`endif

    assign ch_ok   = {1'b0, cfg_ch} < (CH_W + 1)'(NUM_CH);
    assign capture = cfg_valid && !pend_q && ch_ok;

    always_comb begin
        pend_d  = pend_q;
        pch_d   = pch_q;
        phalf_d = phalf_q;
        if (capture) begin
            pend_d  = 1'b1;
            pch_d   = cfg_ch;
            phalf_d = cfg_half;
        end else if (|apply) begin
            pend_d = 1'b0;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            pend_q  <= 1'b0;
            pch_q   <= '0;
            phalf_q <= '0;
        end else begin
            pend_q  <= pend_d;
            pch_q   <= pch_d;
            phalf_q <= phalf_d;
        end
    end

    // Slot occupancy is itself a register, so cfg_ready is registered.
    assign cfg_ready = !pend_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign apply[i] = pend_q && (pch_q == CH_W'(i)) && tc[i];

        freq_div_ch #(
            .CNT_W    (CNT_W),
            .DEF_HALF (DEFAULT_HALF[i])
        ) u_ch (
            .clk_i   (sys_clk),
            .rst_i   (rst),
            .en_i    (ch_en[i]),
            .align_i (align),
            .apply_i (apply[i]),
            .half_i  (phalf_q),
            .tc_o    (tc[i]),
            .clk_o   (clk_out[i]),
            .tick_o  (tick[i])
        );
    end

endmodule

// File: tb/tb_freq_div_multi.sv
// Directed bench for freq_div_multi with halves {9,4,1}.
module tb_freq_div_multi;

    localparam int NCH = 3;
    localparam int CW  = 8;

    logic           sys_clk = 1'b0;
    logic           rst = 1'b1;
    logic [NCH-1:0] ch_en = '0;
    logic           cfg_valid = 1'b0;
    logic           cfg_ready;
    logic [1:0]     cfg_ch = '0;
    logic [CW-1:0]  cfg_half = '0;
    logic [NCH-1:0] clk_out;
    logic [NCH-1:0] tick;
`ifdef FREQ_DIV_SYNC_ALIGN_EN
    logic           sync_align = 1'b0;
`endif

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int hv [NCH] = '{9, 4, 1};

    freq_div_multi #(
        .NUM_CH       (NCH),
        .CNT_W        (CW),
        .DEFAULT_HALF ('{8'd9, 8'd4, 8'd1})
    ) dut (
        .sys_clk   (sys_clk),
        .rst       (rst),
        .ch_en     (ch_en),
`ifdef FREQ_DIV_SYNC_ALIGN_EN
        .sync_align(sync_align),
`endif
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_half  (cfg_half),
        .clk_out   (clk_out),
        .tick      (tick)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic step();
        @(posedge sys_clk);
        #1;
        cyc++;
    endtask

    function automatic bit exp_clk(int h, int k);
        if (k < h + 2) return 1'b0;
        return ((k - h - 2) % (2 * h + 2)) < (h + 1);
    endfunction

    function automatic bit exp_tick(int h, int k);
        if (k < h + 2) return 1'b0;
        return ((k - h - 2) % (2 * h + 2)) == 0;
    endfunction

    task automatic do_reset(input logic [NCH-1:0] en);
        rst = 1'b1;
        cfg_valid = 1'b0;
        ch_en = '0;
        step();
        step();
        rst = 1'b0;
        ch_en = en;
        cyc = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ch_en = '1;
        step();
        step();
        checks++;
        if (clk_out !== 3'b000 || tick !== 3'b000 || cfg_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset clk=%b tick=%b rdy=%b exp 000/000/1",
                     clk_out, tick, cfg_ready);
        end
    endtask

    task automatic test_periods();
        bit ec, et;
        do_reset(3'b111);
        for (int k = 1; k <= 44; k++) begin
            step();
            for (int c = 0; c < NCH; c++) begin
                ec = exp_clk(hv[c], k);
                et = exp_tick(hv[c], k);
                checks++;
                if (clk_out[c] !== ec || tick[c] !== et) begin
                    failures++;
                    $display("FAIL periods k=%0d ch=%0d clk=%b tick=%b exp %b/%b",
                             k, c, clk_out[c], tick[c], ec, et);
                end
            end
        end
    endtask

    task automatic test_reconfig();
        bit ec, et, er;
        do_reset(3'b111);
        while (cyc < 7) step();
        cfg_valid = 1'b1;
        cfg_ch = 2'd1;
        cfg_half = 8'd2;
        step();
        cfg_valid = 1'b0;
        for (int k = 8; k <= 26; k++) begin
            if (k > 8) step();
            er = !(k >= 8 && k <= 10);
            if (k < 11) ec = (k >= 6 && k <= 10);
            else ec = (k >= 14) && ((k - 14) % 6 < 3);
            et = (k >= 14) && ((k - 14) % 6 == 0);
            checks++;
            if (clk_out[1] !== ec || tick[1] !== et || cfg_ready !== er) begin
                failures++;
                $display("FAIL reconfig k=%0d clk=%b tick=%b rdy=%b exp %b/%b/%b",
                         k, clk_out[1], tick[1], cfg_ready, ec, et, er);
            end
        end
    endtask

    task automatic test_disable();
        bit e0, t0;
        do_reset(3'b111);
        while (cyc < 14) step();
        ch_en = 3'b100;
        for (int k = 15; k <= 45; k++) begin
            step();
            if (k == 30) ch_en = 3'b101;
            if (k <= 20) e0 = 1'b1;
            else if (k <= 40) e0 = 1'b0;
            else e0 = ((k - 41) % 20) < 10;
            t0 = (k == 41);
            checks++;
            if (clk_out[1:0] !== {1'b0, e0} || tick[1:0] !== {1'b0, t0}) begin
                failures++;
                $display("FAIL disable k=%0d clk=%b tick=%b exp %b/%b",
                         k, clk_out[1:0], tick[1:0], {1'b0, e0}, {1'b0, t0});
            end
        end
    endtask

    task automatic test_back_to_back_invalid();
        bit ec;
        do_reset(3'b111);
        cfg_valid = 1'b1;
        cfg_ch = 2'd3;
        cfg_half = 8'd0;
        for (int k = 1; k <= 24; k++) begin
            step();
            if (k == 4) cfg_valid = 1'b0;
            checks++;
            if (cfg_ready !== 1'b1) begin
                failures++;
                $display("FAIL invalid_rdy k=%0d rdy=%b exp 1", k, cfg_ready);
            end
            for (int c = 0; c < NCH; c++) begin
                ec = exp_clk(hv[c], k);
                checks++;
                if (clk_out[c] !== ec) begin
                    failures++;
                    $display("FAIL invalid_clk k=%0d ch=%0d clk=%b exp %b",
                             k, c, clk_out[c], ec);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        bit ec;
        do_reset(3'b111);
        while (cyc < 7) step();
        cfg_valid = 1'b1;
        cfg_ch = 2'd0;
        cfg_half = 8'd0;
        step();
        cfg_valid = 1'b0;
        checks++;
        if (cfg_ready !== 1'b0) begin
            failures++;
            $display("FAIL midrst_capture rdy=%b exp 0", cfg_ready);
        end
        step();
        rst = 1'b1;
        step();
        checks++;
        if (clk_out !== 3'b000 || tick !== 3'b000 || cfg_ready !== 1'b1) begin
            failures++;
            $display("FAIL midrst clk=%b tick=%b rdy=%b exp 000/000/1",
                     clk_out, tick, cfg_ready);
        end
        rst = 1'b0;
        cyc = 0;
        for (int k = 1; k <= 24; k++) begin
            step();
            for (int c = 0; c < NCH; c++) begin
                ec = exp_clk(hv[c], k);
                checks++;
                if (clk_out[c] !== ec) begin
                    failures++;
                    $display("FAIL midrst_run k=%0d ch=%0d clk=%b exp %b",
                             k, c, clk_out[c], ec);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_periods();
        test_reconfig();
        test_disable();
        test_back_to_back_invalid();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
